pipelined_inst_decoder: RTL and testbench

- Registered, parametrised decode stage for the 32-bit five-stage core; sits between the F/D and D/X latches.
- Decodes opcode inst[31:27] and, for R-type, ALU op inst[6:2] into a packed control bus.
- Holds its output under downstream stall, bubbles on flush, and decodes a configurable bank of timer opcodes.
- Sequences the multi-cycle mult/div unit and back-pressures fetch while that unit is busy.

---
 rtl/pipelined_inst_decoder.sv | 174 +++++++++++++++++
 tb/tb_pipelined_inst_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_inst_decoder.sv
// Registered decode stage for the 32-bit five-stage core.
// Turns opcode inst[31:27] (and the R-type ALU op inst[6:2]) into a packed
// 16-bit control bus and a one-hot timer select, both registered.
// Holds under downstream stall and bubbles on flush.
// Sequences the multi-cycle mult/div unit and back-pressures fetch while it runs.
module pipelined_inst_decoder #(
   parameter int NUM_TIMERS   = 3,
   parameter int TIMER_BASE   = 24,
   parameter int RAND_OPCODE  = 27,
   parameter int MULT_LATENCY = 4,
   parameter int DIV_LATENCY  = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [31:0]           in_inst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  out_stall,
   input  logic                  flush,
   output logic                  out_valid,
   output logic [31:0]           out_inst,
   output logic [15:0]           out_ctrl,
   output logic [NUM_TIMERS-1:0] out_timer_sel,
   output logic                  md_start,
   output logic                  md_busy,
   output logic                  md_done,
   output logic                  md_abort
);

   localparam logic [4:0] RAND_OP  = 5'(RAND_OPCODE);
   localparam logic [4:0] MULT_CNT = 5'(MULT_LATENCY - 1);
   localparam logic [4:0] DIV_CNT  = 5'(DIV_LATENCY - 1);

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   logic [4:0]            opcode;
   logic [4:0]            aluop;
   logic                  is_nop;
   logic                  timer_hit;
   logic                  legal;
   logic [NUM_TIMERS-1:0] timer_dec;
   logic [15:0]           ctrl_dec;
   logic                  accept;
   logic                  md_launch;

   logic                  out_valid_q;
   logic [31:0]           out_inst_q;
   logic [15:0]           out_ctrl_q;
   logic [NUM_TIMERS-1:0] out_timer_q;

   md_state_t             md_state_q;
   logic [4:0]            md_cnt_q;
   logic                  md_start_q;
   logic                  md_abort_q;

   assign opcode = in_inst[31:27];
   assign aluop  = in_inst[6:2];
   assign is_nop = (in_inst == 32'd0);

   // One comparator per timer opcode; an all-zero word never selects a timer.
   for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_timer
      localparam logic [4:0] TIMER_OP = 5'(TIMER_BASE + gi);
      assign timer_dec[gi] = !is_nop && (opcode == TIMER_OP);
   end

   assign timer_hit = |timer_dec;

   // Anything not in a known opcode group or the timer range is flagged illegal.
   assign legal = (opcode <= 5'd8) || (opcode == 5'd21) || (opcode == 5'd22) ||
                  (opcode == RAND_OP) || timer_hit;

   // Combinational control decode; the all-zero NOP forces every control low.
   always_comb begin
      ctrl_dec     = '0;
      ctrl_dec[0]  = (opcode == 5'd2);
      ctrl_dec[1]  = (opcode == 5'd6);
      ctrl_dec[2]  = (opcode inside {5'd0, 5'd3, 5'd5, 5'd8, 5'd21}) || (opcode == RAND_OP);
      ctrl_dec[3]  = (opcode inside {5'd5, 5'd7, 5'd8, 5'd21});
      ctrl_dec[4]  = (opcode == 5'd8);
      ctrl_dec[5]  = (opcode == 5'd7);
      ctrl_dec[6]  = (opcode inside {5'd1, 5'd3, 5'd4});
      ctrl_dec[7]  = (opcode inside {5'd1, 5'd3});
      ctrl_dec[8]  = (opcode == 5'd21);
      ctrl_dec[9]  = (opcode == 5'd22);
      ctrl_dec[10] = (opcode inside {5'd2, 5'd4, 5'd6, 5'd7});
      ctrl_dec[11] = (opcode != 5'd0);
      ctrl_dec[12] = (opcode == 5'd0) && (aluop == 5'd6);
      ctrl_dec[13] = (opcode == 5'd0) && (aluop == 5'd7);
      ctrl_dec[14] = (opcode == RAND_OP);
      ctrl_dec[15] = !legal;
      if (is_nop) begin
         ctrl_dec = '0;
      end
   end

   assign in_ready  = !out_stall && !md_busy;
   assign accept    = in_ready && in_valid;
   assign md_launch = accept && !flush && (ctrl_dec[12] || ctrl_dec[13]);

   // Decode output register: flush beats stall beats capture beats bubble.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_inst_q  <= '0;
         out_ctrl_q  <= '0;
         out_timer_q <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         out_ctrl_q  <= '0;
         out_timer_q <= '0;
      end else if (out_stall) begin
         out_valid_q <= out_valid_q;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_inst_q  <= in_inst;
         out_ctrl_q  <= ctrl_dec;
         out_timer_q <= timer_dec;
      end else if (in_ready) begin
         out_valid_q <= 1'b0;
         out_ctrl_q  <= '0;
         out_timer_q <= '0;
      end
   end

   // Mult/div sequencer: counts LAT-1 down to 0, start/abort are one-cycle pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         md_state_q <= MD_IDLE;
         md_cnt_q   <= '0;
         md_start_q <= 1'b0;
         md_abort_q <= 1'b0;
      end else begin
         md_start_q <= 1'b0;
         md_abort_q <= 1'b0;
         case (md_state_q)
            MD_IDLE: begin
               if (md_launch) begin
                  md_state_q <= MD_BUSY;
                  md_cnt_q   <= ctrl_dec[13] ? DIV_CNT : MULT_CNT;
                  md_start_q <= 1'b1;
               end
            end
            MD_BUSY: begin
               if (flush) begin
                  md_state_q <= MD_IDLE;
                  md_cnt_q   <= '0;
                  md_abort_q <= 1'b1;
               end else if (md_cnt_q == 5'd0) begin
                  md_state_q <= MD_IDLE;
               end else begin
                  md_cnt_q   <= md_cnt_q - 5'd1;
               end
            end
            default: begin
               md_state_q <= MD_IDLE;
               md_cnt_q   <= '0;
            end
         endcase
      end
   end

   assign md_busy       = (md_state_q == MD_BUSY);
   assign md_done       = md_busy && (md_cnt_q == 5'd0);
   assign md_start      = md_start_q;
   assign md_abort      = md_abort_q;
   assign out_valid     = out_valid_q;
   assign out_inst      = out_inst_q;
   assign out_ctrl      = out_ctrl_q;
   assign out_timer_sel = out_timer_q;

endmodule

// File: tb/tb_pipelined_inst_decoder.sv
// Directed testbench for pipelined_inst_decoder: one task per scenario,
// inputs driven and outputs sampled on the falling clock edge.
module tb_pipelined_inst_decoder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_inst = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        out_stall = 1'b0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [15:0] out_ctrl;
   logic [2:0]  out_timer_sel;
   logic        md_start;
   logic        md_busy;
   logic        md_done;
   logic        md_abort;

   int checks = 0;
   int errors = 0;

   pipelined_inst_decoder #(
      .NUM_TIMERS(3), .TIMER_BASE(24), .RAND_OPCODE(27),
      .MULT_LATENCY(4), .DIV_LATENCY(8)
   ) dut (
      .clock(clock), .reset(reset), .in_inst(in_inst), .in_valid(in_valid),
      .in_ready(in_ready), .out_stall(out_stall), .flush(flush),
      .out_valid(out_valid), .out_inst(out_inst), .out_ctrl(out_ctrl),
      .out_timer_sel(out_timer_sel), .md_start(md_start), .md_busy(md_busy),
      .md_done(md_done), .md_abort(md_abort)
   );

   always #5 clock = ~clock;

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || out_timer_sel !== 3'b0 || out_inst !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs valid=%b ctrl=%h tsel=%b inst=%h required 0/0000/000/00000000",
                  out_valid, out_ctrl, out_timer_sel, out_inst);
      end
      checks++;
      if (md_start !== 1'b0 || md_busy !== 1'b0 || md_done !== 1'b0 || md_abort !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_md start=%b busy=%b done=%b abort=%b ready=%b required 0000 ready=1",
                  md_start, md_busy, md_done, md_abort, in_ready);
      end
      reset = 1'b0;
      @(negedge clock);
      $display("reset released");
   endtask

   task automatic test_addi;
      in_inst  = 32'h2800_0000;
      in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== 16'h080C || out_inst !== 32'h2800_0000 || out_timer_sel !== 3'b000) begin
         errors++;
         $display("FAIL addi valid=%b ctrl=%h inst=%h tsel=%b required 1/080c/28000000/000",
                  out_valid, out_ctrl, out_inst, out_timer_sel);
      end
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 16'h0) begin
         errors++;
         $display("FAIL addi_bubble valid=%b ctrl=%h required 0/0000", out_valid, out_ctrl);
      end
      $display("addi ctrl=%h", 16'h080C);
   endtask

   task automatic test_mul;
      in_inst  = 32'h0000_0018;
      in_valid = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clock);
         in_valid = 1'b0;
         checks++;
         if (md_start !== (c == 1) || md_busy !== (c <= 4) || md_done !== (c == 4) ||
             in_ready !== (c > 4) || md_abort !== 1'b0) begin
            errors++;
            $display("FAIL mul_cycle%0d start=%b busy=%b done=%b ready=%b abort=%b required %b%b%b%b0",
                     c, md_start, md_busy, md_done, in_ready, md_abort,
                     (c == 1), (c <= 4), (c == 4), (c > 4));
         end
         checks++;
         if (out_valid !== 1'b1 || out_ctrl !== 16'h1004) begin
            errors++;
            $display("FAIL mul_ctrl_cycle%0d valid=%b ctrl=%h required 1/1004", c, out_valid, out_ctrl);
         end
      end
      @(negedge clock);
      $display("mul sequence done");
   endtask

   task automatic test_div_flush;
      in_inst  = 32'h0000_001C;
      in_valid = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clock);
         in_valid = 1'b0;
         flush    = 1'b0;
         if (c == 1) begin
            checks++;
            if (md_start !== 1'b1 || out_ctrl !== 16'h2004 || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL div_start start=%b ctrl=%h valid=%b required 1/2004/1", md_start, out_ctrl, out_valid);
            end
         end
         if (c == 3) flush = 1'b1;
         if (c == 4) begin
            checks++;
            if (md_busy !== 1'b0 || md_abort !== 1'b1 || out_valid !== 1'b0 || out_ctrl !== 16'h0) begin
               errors++;
               $display("FAIL div_abort busy=%b abort=%b valid=%b ctrl=%h required 0/1/0/0000",
                        md_busy, md_abort, out_valid, out_ctrl);
            end
         end
         if (c == 5) begin
            checks++;
            if (md_abort !== 1'b0 || md_busy !== 1'b0) begin
               errors++;
               $display("FAIL div_abort_pulse abort=%b busy=%b required 0/0", md_abort, md_busy);
            end
         end
         checks++;
         if (md_done !== 1'b0) begin
            errors++;
            $display("FAIL div_no_done cycle%0d done=%b required 0", c, md_done);
         end
      end
      $display("div flush done");
   endtask

   task automatic test_back_to_back;
      logic [31:0] insts [12];
      logic [15:0] ctrls [12];
      logic [2:0]  tsels [12];
      insts = '{32'hC800_0000, 32'h4800_0000, 32'hC000_0000, 32'hD000_0000,
                32'hD800_0000, 32'h4000_0000, 32'h3800_0000, 32'h1000_0000,
                32'h1800_0000, 32'hA800_0000, 32'hB000_0000, 32'hE000_0000};
      ctrls = '{16'h0800, 16'h8800, 16'h0800, 16'h0800,
                16'h4804, 16'h081C, 16'h0C28, 16'h0C01,
                16'h08C4, 16'h090C, 16'h0A00, 16'h8800};
      tsels = '{3'b010, 3'b000, 3'b001, 3'b100,
                3'b000, 3'b000, 3'b000, 3'b000,
                3'b000, 3'b000, 3'b000, 3'b000};
      in_inst  = insts[0];
      in_valid = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clock);
         checks++;
         if (out_valid !== 1'b1 || out_ctrl !== ctrls[i-1] || out_timer_sel !== tsels[i-1] ||
             out_inst !== insts[i-1]) begin
            errors++;
            $display("FAIL decode_%h valid=%b ctrl=%h tsel=%b inst=%h required 1/%h/%b/%h",
                     insts[i-1], out_valid, out_ctrl, out_timer_sel, out_inst,
                     ctrls[i-1], tsels[i-1], insts[i-1]);
         end else begin
            $display("decode %h ctrl=%h tsel=%b", insts[i-1], out_ctrl, out_timer_sel);
         end
         if (i < 12) in_inst = insts[i];
         else in_valid = 1'b0;
      end
      @(negedge clock);
   endtask

   task automatic test_nop_stall;
      in_inst  = 32'h0000_0000;
      in_valid = 1'b1;
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== 16'h0 || out_timer_sel !== 3'b0) begin
         errors++;
         $display("FAIL nop valid=%b ctrl=%h tsel=%b required 1/0000/000", out_valid, out_ctrl, out_timer_sel);
      end
      in_inst   = 32'h2800_0000;
      out_stall = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clock);
         checks++;
         if (out_valid !== 1'b1 || out_ctrl !== 16'h0 || out_inst !== 32'h0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_cycle%0d valid=%b ctrl=%h inst=%h ready=%b required 1/0000/00000000/0",
                     c, out_valid, out_ctrl, out_inst, in_ready);
         end
      end
      out_stall = 1'b0;
      @(negedge clock);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== 16'h080C || out_inst !== 32'h2800_0000) begin
         errors++;
         $display("FAIL stall_release valid=%b ctrl=%h inst=%h required 1/080c/28000000",
                  out_valid, out_ctrl, out_inst);
      end
      @(negedge clock);
      $display("nop and stall done");
   endtask

   task automatic test_async_reset;
      in_inst  = 32'h0000_001C;
      in_valid = 1'b1;
      repeat (2) @(negedge clock);
      in_valid = 1'b0;
      checks++;
      if (md_busy !== 1'b1) begin
         errors++;
         $display("FAIL async_pre_busy busy=%b required 1", md_busy);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (md_busy !== 1'b0 || out_valid !== 1'b0 || md_done !== 1'b0 || md_start !== 1'b0 || md_abort !== 1'b0) begin
         errors++;
         $display("FAIL async_reset busy=%b valid=%b done=%b start=%b abort=%b required 00000",
                  md_busy, out_valid, md_done, md_start, md_abort);
      end
      #1 reset = 1'b0;
      @(negedge clock);
      checks++;
      if (md_busy !== 1'b0 || md_abort !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_after busy=%b abort=%b ready=%b required 0/0/1", md_busy, md_abort, in_ready);
      end
      $display("async reset done");
   endtask

   initial begin
      test_reset();
      test_addi();
      test_mul();
      test_div_flush();
      test_back_to_back();
      test_nop_stall();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
